// File: rtl/pkt_prior_drain.sv
// Dequeue-side reader for the packet priority queue.
// Issues one dequeue request at a time, buffers responses in a 2-entry FIFO
// feeding a valid/ready egress stream, checks priority ordering and keeps
// pop/timeout statistics.
//
// state | meaning
// IDLE  | no request outstanding; issue one when enabled, queue non-empty, FIFO has room
// REQ   | deq_en pulse cycle
// WAIT  | awaiting deq_valid; down-counter abandons the request after TIMEOUT cycles
module pkt_prior_drain #(
   parameter int DWIDTH    = 64,
   parameter int PWIDTH    = 16,
   parameter int TIMEOUT   = 16,
   parameter bit ASCENDING = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              pq_nonempty,
   output logic              deq_en,
   input  logic              deq_valid,
   input  logic [DWIDTH-1:0] deq_data,
   input  logic [PWIDTH-1:0] deq_prior,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DWIDTH-1:0] m_data,
   output logic [PWIDTH-1:0] m_prior,
   output logic              busy,
   output logic              order_err,
   output logic [31:0]       pop_cnt,
   output logic [15:0]       timeout_cnt
);

   // Timer holds TIMEOUT-1 down to 0, giving exactly TIMEOUT cycles in WAIT.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              deq_en_q, deq_en_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DWIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic [PWIDTH-1:0] head_prior_q, head_prior_d, tail_prior_q, tail_prior_d;
   logic [PWIDTH-1:0] prev_q, prev_d;
   logic              prev_vld_q, prev_vld_d;
   logic              order_err_q, order_err_d;
   logic [31:0]       pop_cnt_q, pop_cnt_d;
   logic [15:0]       timeout_cnt_q, timeout_cnt_d;

   logic push, pop, tmo, viol;

   // Request sequencing: next state, deq_en pulse, response accept / timeout.
   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      deq_en_d = 1'b0;
      push     = 1'b0;
      tmo      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en && pq_nonempty && (cnt_q < 2'd2)) begin
               state_d  = ST_REQ;
               deq_en_d = 1'b1;
            end
         end
         ST_REQ: begin
            state_d = ST_WAIT;
            tmr_d   = TW'(TIMEOUT - 1);
         end
         ST_WAIT: begin
            if (deq_valid) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end else if (tmr_q == '0) begin
               tmo     = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Two-entry FIFO; head registers drive the stream and hold when empty.
   always_comb begin
      pop          = (cnt_q != 2'd0) && m_ready;
      cnt_d        = cnt_q;
      head_data_d  = head_data_q;
      head_prior_d = head_prior_q;
      tail_data_d  = tail_data_q;
      tail_prior_d = tail_prior_q;
      case ({push, pop})
         2'b10: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd0) begin
               head_data_d  = deq_data;
               head_prior_d = deq_prior;
            end else begin
               tail_data_d  = deq_data;
               tail_prior_d = deq_prior;
            end
         end
         2'b01: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd2) begin
               head_data_d  = tail_data_q;
               head_prior_d = tail_prior_q;
            end
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               head_data_d  = deq_data;
               head_prior_d = deq_prior;
            end else begin
               head_data_d  = tail_data_q;
               head_prior_d = tail_prior_q;
               tail_data_d  = deq_data;
               tail_prior_d = deq_prior;
            end
         end
         default: ;
      endcase
   end

   // Order check against the previously accepted priority, plus statistics.
   always_comb begin
      viol          = ASCENDING ? (deq_prior < prev_q) : (deq_prior > prev_q);
      prev_d        = prev_q;
      prev_vld_d    = prev_vld_q;
      order_err_d   = order_err_q;
      pop_cnt_d     = pop_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      if (push) begin
         pop_cnt_d  = pop_cnt_q + 32'd1;
         prev_d     = deq_prior;
         prev_vld_d = 1'b1;
         if (prev_vld_q && viol) order_err_d = 1'b1;
      end
      if (tmo && (timeout_cnt_q != 16'hFFFF)) timeout_cnt_d = timeout_cnt_q + 16'd1;
   end

   // State, FIFO and statistics registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         tmr_q         <= '0;
         deq_en_q      <= 1'b0;
         cnt_q         <= 2'd0;
         head_data_q   <= '0;
         head_prior_q  <= '0;
         tail_data_q   <= '0;
         tail_prior_q  <= '0;
         prev_q        <= '0;
         prev_vld_q    <= 1'b0;
         order_err_q   <= 1'b0;
         pop_cnt_q     <= 32'd0;
         timeout_cnt_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         deq_en_q      <= deq_en_d;
         cnt_q         <= cnt_d;
         head_data_q   <= head_data_d;
         head_prior_q  <= head_prior_d;
         tail_data_q   <= tail_data_d;
         tail_prior_q  <= tail_prior_d;
         prev_q        <= prev_d;
         prev_vld_q    <= prev_vld_d;
         order_err_q   <= order_err_d;
         pop_cnt_q     <= pop_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

   assign deq_en      = deq_en_q;
   assign m_valid     = (cnt_q != 2'd0);
   assign m_data      = head_data_q;
   assign m_prior     = head_prior_q;
   assign busy        = (state_q != ST_IDLE);
   assign order_err   = order_err_q;
   assign pop_cnt     = pop_cnt_q;
   assign timeout_cnt = timeout_cnt_q;

endmodule

// File: doc/pkt_prior_drain.md
Name: pkt_prior_drain

Overview:
- Dequeue-side reader for the packet priority queue: pulls entries one at a time from the queue's dequeue port.
- Buffers entries in a 2-entry output FIFO and presents them on a valid/ready stream to the egress stage.
- Checks that popped priorities arrive in the order the queue claims to maintain; keeps pop and timeout statistics.

Parameters:
DWIDTH, 64, width of dequeued data word
PWIDTH, 16, width of priority value
TIMEOUT, 16, max cycles in WAIT for deq_valid before abandoning a request (>=1)
ASCENDING, 1, 1: popped priorities must be non-decreasing; 0: non-increasing

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
en  in  1  enables issuing new dequeue requests
pq_nonempty  in  1  queue holds at least one entry
deq_en  out  1  dequeue request, one-cycle pulse
deq_valid  in  1  queue response strobe
deq_data  in  DWIDTH  response data, valid with deq_valid
deq_prior  in  PWIDTH  response priority, valid with deq_valid
m_valid  out  1  output stream valid
m_ready  in  1  output stream ready
m_data  out  DWIDTH  FIFO head data
m_prior  out  PWIDTH  FIFO head priority
busy  out  1  state != IDLE
order_err  out  1  sticky priority-order violation
pop_cnt  out  32  successful pops, wrapping
timeout_cnt  out  16  abandoned requests, saturating at 16'hFFFF

Behaviour:
- Reset (rst low, asynchronous), all outputs 0:
  - state=IDLE, deq_en=0, FIFO empty (m_valid=0, m_data=0, m_prior=0), busy=0, order_err=0, pop_cnt=0, timeout_cnt=0, no previous priority held.
  - Reset mid-request discards the request and all buffered entries.
- FSM states: IDLE, REQ, WAIT.
  - IDLE->REQ when en && pq_nonempty && fifo_count<2.
  - REQ: deq_en=1 (registered, exactly one cycle); always ->WAIT next cycle.
  - WAIT->IDLE on deq_valid: entry is pushed into the FIFO that same edge.
  - WAIT->IDLE after TIMEOUT cycles without deq_valid: timeout_cnt+1 (saturating), nothing pushed.
- deq_valid timing:
  - Sampled only in WAIT; ignored in IDLE and REQ (no push, no count). A late response after a timeout is dropped.
  - Earliest response is the cycle after deq_en. One outstanding request at most.
- Latency and throughput:
  - en/pq_nonempty sampled at edge t -> deq_en high during cycle t+1.
  - Response sampled at edge u -> m_valid high from u+1.
  - Peak throughput is one pop per 3 cycles.
- FIFO:
  - 2 entries. m_data/m_prior show the head, registered.
  - Pop on m_valid && m_ready. Push and pop in the same cycle are both performed; count unchanged.
  - Never overflows: a request issues only when count<2, and only one request is outstanding.
  - m_data/m_prior hold their last value when the FIFO is empty.
- Order check, evaluated on each accepted response:
  - If a previous priority is held: compare deq_prior with it. ASCENDING=1: deq_prior < prev sets order_err. ASCENDING=0: deq_prior > prev sets order_err.
  - prev <= deq_prior after the comparison. The first pop after reset is not checked.
  - order_err stays set until reset.
  - Equal priorities are legal.
- pop_cnt increments on each accepted response and wraps at 2^32.
- en low: no new request issued. An in-flight REQ/WAIT still completes normally.
- pq_nonempty dropping after request issue has no effect on the request; the response or timeout resolves it.

Test Plan:
- Single pop, response 1 cycle after deq_en:
  - en=1, pq_nonempty=1, m_ready=1; deq_data=64'd114514, deq_prior=5.
  - Required: deq_en pulse 1 cycle; m_valid 1 cycle with m_data=114514, m_prior=5; pop_cnt=1; order_err=0.
- Backpressure:
  - m_ready=0; queue answers each request with priorities 1,2,3.
  - Required: exactly 2 deq_en pulses, then IDLE with no further requests.
  - Raising m_ready outputs 1 then 2, then a third request fetches 3.
- Timeout, TIMEOUT=4:
  - deq_valid never asserted.
  - Required: WAIT lasts 4 cycles, then IDLE; timeout_cnt=1; no push; a late deq_valid in IDLE is ignored; pop_cnt unchanged.
- Order check, ASCENDING=1:
  - Priorities 3,3,7,2,9.
  - Required: order_err rises on the edge accepting 2 and stays 1 after 9; pop_cnt=5. The same sequence with ASCENDING=0 sets the flag at 7.
- Async reset mid-WAIT with one FIFO entry:
  - rst low between edges.
  - Required: immediately m_valid=0, deq_en=0, busy=0, all counters 0; after release, the first pop is not order-checked.
- Simultaneous push and pop:
  - FIFO holds 1 entry, m_ready=1, deq_valid accepted the same cycle.
  - Required: count stays 1, the head advances to the new entry, no data lost or duplicated.
